// File: rtl/result_drain.sv
// Snapshots all LANES partial-sum lanes on capture_req and streams them one per
// beat over valid/ready. Optional ReLU+saturate at capture: RESULT_DRAIN_RELU_SAT_EN.
module result_drain #(
   parameter int  DATA_WIDTH = 8,
   parameter int  BLOCK_SIZE = 4,
   parameter int  ARRAY_SIZE = 4,
   localparam int LANES      = BLOCK_SIZE * ARRAY_SIZE,
   localparam int OUT_WIDTH  = 4 * DATA_WIDTH,
   localparam int LW         = $clog2(LANES)
) (
   input  logic                       Clk,
   input  logic                       rst,
   input  logic [LANES*OUT_WIDTH-1:0] Array_Output_flat,
   input  logic                       capture_req,
   output logic                       capture_busy,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_WIDTH-1:0]       out_data,
   output logic [LW-1:0]              out_lane,
   output logic                       out_last,
   output logic                       drain_done,
   output logic                       overrun_err,
   input  logic                       clear_err
);

   typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

`ifdef RESULT_DRAIN_RELU_SAT_EN
   localparam logic [OUT_WIDTH-1:0] SAT_MAX = OUT_WIDTH'((64'd1 << DATA_WIDTH) - 64'd1);

   function automatic logic [OUT_WIDTH-1:0] relu_sat(input logic [OUT_WIDTH-1:0] v);
      if (v[OUT_WIDTH-1])  return '0;
      else if (v > SAT_MAX) return SAT_MAX;
      else                  return v;
   endfunction
`endif

   state_t                             state_q, state_d;
   logic [LW-1:0]                      lane_q, lane_d;
   logic [LANES-1:0][OUT_WIDTH-1:0]    shadow_q, shadow_d;
   logic                               valid_q, valid_d;
   logic                               busy_q, busy_d;
   logic                               last_q, last_d;
   logic                               done_q, done_d;
   logic                               err_q, err_d;

   always_comb begin
      state_d  = state_q;
      lane_d   = lane_q;
      shadow_d = shadow_q;
      valid_d  = valid_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (capture_req) begin
               for (int i = 0; i < LANES; i++) begin
`ifdef RESULT_DRAIN_RELU_SAT_EN
                  shadow_d[i] = relu_sat(Array_Output_flat[i*OUT_WIDTH +: OUT_WIDTH]);
`else
                  shadow_d[i] = Array_Output_flat[i*OUT_WIDTH +: OUT_WIDTH];
`endif
               end
               state_d = DRAIN;
               lane_d  = '0;
               valid_d = 1'b1;
               busy_d  = 1'b1;
            end
         end
         DRAIN: begin
            // out_valid is always high here, so out_ready alone completes the beat
            if (out_ready) begin
               if (lane_q == LW'(LANES-1)) begin
                  state_d = DONE;
                  lane_d  = '0;
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  lane_d = lane_q + 1'b1;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      last_d = valid_d && (lane_d == LW'(LANES-1));
      // a request outside IDLE is dropped but flagged; set beats clear
      if (capture_req && state_q != IDLE) err_d = 1'b1;
      else if (clear_err)                 err_d = 1'b0;
      else                                err_d = err_q;
   end

   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         lane_q   <= '0;
         shadow_q <= '0;
         valid_q  <= 1'b0;
         busy_q   <= 1'b0;
         last_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lane_q   <= lane_d;
         shadow_q <= shadow_d;
         valid_q  <= valid_d;
         busy_q   <= busy_d;
         last_q   <= last_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign out_data     = shadow_q[lane_q];
   assign out_lane     = lane_q;
   assign out_valid    = valid_q;
   assign out_last     = last_q;
   assign capture_busy = busy_q;
   assign drain_done   = done_q;
   assign overrun_err  = err_q;

endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain: reset, drain, backpressure, isolation, overrun, clamp.
module tb_result_drain;
   localparam int LANES = 16;
   localparam int OW    = 32;
   localparam int LW    = 4;

   logic             Clk = 1'b0;
   logic             rst, capture_req, out_ready, clear_err;
   logic [LANES*OW-1:0] arr;
   logic             capture_busy, out_valid, out_last, drain_done, overrun_err;
   logic [OW-1:0]    out_data;
   logic [LW-1:0]    out_lane;

   int pass_cnt = 0;
   int total    = 0;

   always #5 Clk = ~Clk;

   result_drain dut (
      .Clk(Clk), .rst(rst), .Array_Output_flat(arr), .capture_req(capture_req),
      .capture_busy(capture_busy), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_lane(out_lane), .out_last(out_last),
      .drain_done(drain_done), .overrun_err(overrun_err), .clear_err(clear_err)
   );

   task automatic tick;
      @(posedge Clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic load_ramp(input logic [31:0] base);
      for (int i = 0; i < LANES; i++) arr[i*OW +: OW] = base + 32'(i);
   endtask

   task automatic capture;
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
   endtask

   initial begin
      logic [3:0]  pat;
      logic [31:0] relu_exp [4];
      int idx;
      bit seen_done;

      rst = 1'b0; capture_req = 1'b0; out_ready = 1'b0; clear_err = 1'b0;
      load_ramp(32'h100);
      tick(); tick();
      chk("rst_valid", 32'(out_valid), 0);
      chk("rst_busy",  32'(capture_busy), 0);
      chk("rst_lane",  32'(out_lane), 0);
      chk("rst_data",  out_data, 0);
      chk("rst_last",  32'(out_last), 0);
      chk("rst_done",  32'(drain_done), 0);
      chk("rst_err",   32'(overrun_err), 0);
      rst = 1'b1;
      tick();

      // basic drain, with the input bus trashed right after capture
      out_ready = 1'b1;
      capture();
      arr = '1;
      for (int i = 0; i < LANES; i++) begin
         chk("basic_valid", 32'(out_valid), 1);
         chk("basic_lane",  32'(out_lane), 32'(i));
         chk("basic_data",  out_data, 32'h100 + 32'(i));
         chk("basic_last",  32'(out_last), 32'(i == LANES-1));
         chk("basic_busy",  32'(capture_busy), 1);
         tick();
      end
      chk("basic_done",   32'(drain_done), 1);
      chk("basic_vdrop",  32'(out_valid), 0);
      chk("basic_bdrop",  32'(capture_busy), 0);
      tick();
      chk("basic_done_pulse", 32'(drain_done), 0);

      // backpressure with ready pattern 1,0,0,1
      load_ramp(32'h100);
      out_ready = 1'b0;
      capture();
      pat = 4'b1001;
      idx = 0;
      seen_done = 1'b0;
      for (int c = 0; c < 200 && !seen_done; c++) begin
         out_ready = pat[c % 4];
         if (drain_done) seen_done = 1'b1;
         if (out_valid) begin
            chk("bp_data", out_data, 32'h100 + 32'(idx));
            chk("bp_lane", 32'(out_lane), 32'(idx));
            chk("bp_last", 32'(out_last), 32'(idx == LANES-1));
            if (out_ready) idx++;
         end
         tick();
      end
      chk("bp_finished", 32'(seen_done), 1);
      chk("bp_count", 32'(idx), 16);

      // overrun during drain; snapshot must not change
      load_ramp(32'h100);
      out_ready = 1'b1;
      capture();
      load_ramp(32'hA000);
      for (int i = 0; i < LANES; i++) begin
         chk("ovr_data", out_data, 32'h100 + 32'(i));
         chk("ovr_lane", 32'(out_lane), 32'(i));
         chk("ovr_err",  32'(overrun_err), 32'(i >= 4 && i <= 8));
         capture_req = (i == 3 || i == 6);
         clear_err   = (i == 6 || i == 8);
         tick();
      end
      capture_req = 1'b0; clear_err = 1'b0;
      chk("ovr_done", 32'(drain_done), 1);
      tick();

      // asynchronous reset mid-drain at lane 5
      load_ramp(32'h200);
      capture();
      for (int i = 0; i < 5; i++) tick();
      chk("mid_lane5", 32'(out_lane), 5);
      #2 rst = 1'b0;
      #1;
      chk("mid_valid", 32'(out_valid), 0);
      chk("mid_busy",  32'(capture_busy), 0);
      chk("mid_lane",  32'(out_lane), 0);
      chk("mid_data",  out_data, 0);
      tick();
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("mid_nodone", 32'(drain_done), 0);
         tick();
      end
      load_ramp(32'h300);
      capture();
      chk("mid_restart_valid", 32'(out_valid), 1);
      chk("mid_restart_lane",  32'(out_lane), 0);
      chk("mid_restart_data",  out_data, 32'h300);
      for (int i = 0; i < LANES; i++) tick();
      chk("mid_restart_done", 32'(drain_done), 1);
      tick();

      // clamp-path vectors
      arr = '0;
      arr[0*OW +: OW] = 32'hFFFF_FFFB;
      arr[1*OW +: OW] = 32'h7F;
      arr[2*OW +: OW] = 32'h100;
      arr[3*OW +: OW] = 32'h0;
`ifdef RESULT_DRAIN_RELU_SAT_EN
      relu_exp = '{32'h0, 32'h7F, 32'hFF, 32'h0};
`else
      relu_exp = '{32'hFFFF_FFFB, 32'h7F, 32'h100, 32'h0};
`endif
      capture();
      for (int i = 0; i < 4; i++) begin
         chk("clamp_data", out_data, relu_exp[i]);
         tick();
      end
      for (int i = 4; i < LANES; i++) tick();
      chk("clamp_done", 32'(drain_done), 1);
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
